// File: rtl/streamer_pkg.sv
// Shared types and sample encoding for the RAM sample replay stages.
// Samples are 1-bit captures mapped to signed +1 / -1 at the consumer's width.
package streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Truncating either constant to any width >= 2 keeps its signed meaning.
  localparam logic [31:0] SAMPLE_POS = 32'h0000_0001;
  localparam logic [31:0] SAMPLE_NEG = 32'hFFFF_FFFF;

  function automatic logic [31:0] bit_to_sample(input logic b);
    return b ? SAMPLE_POS : SAMPLE_NEG;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO used to absorb registered-RAM read latency under backpressure.
// Head data comes straight from storage registers, so dout_o has no path from pop_i.
module stream_skid_fifo #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_sample_streamer.sv
// Replays a 1-bit sample RAM as a backpressured signed +/-1 stream with loop and end-of-pass marker.
// Define STREAMER_STALL_CNT_EN to add the saturating stall_count output.
//
//   state | meaning
//   IDLE  | waiting for start, no reads issued
//   RUN   | issuing reads while FIFO + in-flight has room
//   DRAIN | no new reads; emptying in-flight read and FIFO
module ram_sample_streamer
  import streamer_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 16000000,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sample_count
`ifdef STREAMER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              inflight_q;
  logic              tag_q;
  logic              eop_q, eop_d;
  logic              issue;
  logic              hs;
  logic              start_ok;
  logic [1:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;

  stream_skid_fifo #(.W(2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   ({ram_data, tag_q}),
    .pop_i   (hs),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign hs       = m_valid && m_ready;
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign start_ok = (state_q == IDLE) && start && !stop;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    eop_d   = eop_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          ptr_d   = '0;
          eop_d   = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        // a same-cycle pop frees the slot the new read will land in
        end else if (hs || (!fifo_full && (occ < 3'd2))) begin
          issue = 1'b1;
          if (ptr_q == LAST_ADDR) begin
            ptr_d = '0;
            if (!loop_en) begin
              state_d = DRAIN;
              eop_d   = 1'b1;
            end
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          state_d = IDLE;
          done    = eop_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      eop_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      eop_q      <= eop_d;
      inflight_q <= issue;
      tag_q      <= issue && (ptr_q == LAST_ADDR);
      if (issue) addr_q <= ptr_q;
      if (start_ok) cnt_q <= '0;
      else if (hs) cnt_q <= (cnt_q == LAST_ADDR) ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  assign ram_addr     = issue ? ptr_q : addr_q;
  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_empty ? '0 : OUT_W'(bit_to_sample(fifo_head[1]));
  assign m_last       = !fifo_empty && fifo_head[0];
  assign busy         = (state_q != IDLE);
  assign sample_count = cnt_q;

`ifdef STREAMER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (start_ok) stall_q <= '0;
    else if (m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ram_sample_streamer.sv
// Scoreboard bench for ram_sample_streamer with DEPTH=4 and a RAM preloaded 1,0,1,1.
module tb_ram_sample_streamer;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int OUT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] sample_count;
`ifdef STREAMER_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  ram_sample_streamer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count)
`ifdef STREAMER_STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  logic ram_mem [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  always @(posedge clk) ram_data <= ram_mem[ram_addr[1:0]];

  // {m_data, m_last} for addresses 0..3: +1, -1, +1, +1(last)
  logic [4:0] exp_tab [4] = '{5'b0001_0, 5'b1111_0, 5'b0001_0, 5'b0001_1};

  logic [4:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int stall_seen = 0;
  logic       stalled = 1'b0;
  logic [4:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {m_valid, m_data, m_last}, {1'b1, held});
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 32'd1, 32'd0);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("sample_data", m_data, e[4:1]);
          check("sample_last", m_last, e[0]);
        end
      end
      if (m_valid && !m_ready) stall_seen++;
      if (done) done_cnt++;
      stalled = m_valid && !m_ready;
      held    = {m_data, m_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_tab[i % 4]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) tick();
    check("idle_timeout", busy, 0);
  endtask

  task automatic full_pass(input string tag);
    int d0, h0;
    d0 = done_cnt;
    h0 = hs_cnt;
    loop_en = 1'b0;
    m_ready = 1'b1;
    push_seq(4);
    pulse_start();
    check({tag, "_valid_c0"}, m_valid, 0);
    tick();
    check({tag, "_valid_c1"}, m_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check({tag, "_valid_run"}, m_valid, 1);
    end
    tick();
    check({tag, "_valid_end"}, m_valid, 0);
    wait_idle(20);
    check({tag, "_hs"}, hs_cnt - h0, 4);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_count_wrap"}, sample_count, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, h0, given;
    logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    #12;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_done", done, 0);
    check("rst_count", sample_count, 0);
    tick();
    rst = 1'b0;
    tick();

    full_pass("pass");

    // backpressure with ready pattern 1,0,0,1
    d0 = done_cnt;
    h0 = hs_cnt;
    stall_seen = 0;
    push_seq(4);
    pulse_start();
    for (int i = 0; i < 80; i++) begin
      if (!busy && i > 2) break;
      m_ready = rdy_pat[i % 4];
      tick();
    end
    m_ready = 1'b1;
    wait_idle(20);
    check("bp_hs", hs_cnt - h0, 4);
    check("bp_done", done_cnt - d0, 1);
    check("bp_queue_empty", exp_q.size(), 0);
`ifdef STREAMER_STALL_CNT_EN
    check("bp_stall_count", stall_count, stall_seen);
`endif

    // stop after 2 handshakes, looping so no end-of-pass occurs
    d0 = done_cnt;
    h0 = hs_cnt;
    loop_en = 1'b1;
    m_ready = 1'b1;
    push_seq(4);
    pulse_start();
    given = 0;
    for (int k = 0; k < 20 && given < 2; k++) begin
      if (m_valid) given++;
      tick();
    end
    m_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_addr", ram_addr, 3);
    check("stop_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stop_addr_hold", ram_addr, 3);
    end
    m_ready = 1'b1;
    wait_idle(20);
    check("stop_hs", hs_cnt - h0, 4);
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_addr_idle", ram_addr, 3);
    check("stop_queue_empty", exp_q.size(), 0);

    // looping replay for 10 handshakes, then reset mid-stream
    d0 = done_cnt;
    h0 = hs_cnt;
    push_seq(10);
    pulse_start();
    given = 0;
    for (int k = 0; k < 60 && given < 10; k++) begin
      if (m_valid) given++;
      tick();
    end
    m_ready = 1'b0;
    check("loop_hs", hs_cnt - h0, 10);
    check("loop_count", sample_count, 2);
    check("loop_queue_empty", exp_q.size(), 0);
    tick();
    tick();
    check("loop_no_done", done_cnt - d0, 0);
    check("loop_valid_pre_rst", m_valid, 1);
    check("loop_busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", sample_count, 0);
    check("rst_mid_addr", ram_addr, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    loop_en = 1'b0;
    tick();

    // start and stop together from IDLE
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("ss_busy", busy, 0);
      check("ss_valid", m_valid, 0);
      check("ss_addr", ram_addr, 0);
      tick();
    end

    full_pass("replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
